// File: rtl/fifo_burst_reader.sv
// Read-side controller for the 256x32 synchronous FIFO: drains burst_len words
// and re-times them through a 4-entry skid buffer onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [LEN_WIDTH-1:0]  rd_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nxt;
  logic [LEN_WIDTH-1:0]  issue_left, emit_left;
  logic [RD_LATENCY-1:0] pipe;
  logic [2:0]            inflight;
  logic [DATA_WIDTH-1:0] skid [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            occupancy;
  logic                  accept, push, pop;

  assign accept   = (state == IDLE) && start;
  assign push     = pipe[RD_LATENCY-1];
  assign pop      = m_valid && m_ready;
  assign inflight = 3'($countones(pipe));
  assign m_valid  = (occupancy != '0);
  assign m_data   = skid[rd_ptr];

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (burst_len == '0) ? DONE : RUN;
      RUN:     if (pop && (emit_left == LEN_WIDTH'(1))) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Credit covers words buffered plus words still in the read pipe,
  // so every issued read is guaranteed a skid slot on arrival.
  always_comb begin
    busy       = (state == RUN);
    done       = (state == DONE);
    fifo_rd_en = (state == RUN) && !fifo_rd_empty && (issue_left != '0) &&
                 (({1'b0, occupancy} + {1'b0, inflight}) < 4'd4);
    m_last     = m_valid && (state == RUN) && (emit_left == LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      issue_left <= '0;
      emit_left  <= '0;
      rd_count   <= '0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      skid       <= '{default: '0};
    end else begin
      pipe <= RD_LATENCY'({pipe, fifo_rd_en});
      if (accept) begin
        issue_left <= burst_len;
        emit_left  <= burst_len;
        rd_count   <= '0;
      end else begin
        if (fifo_rd_en) issue_left <= issue_left - LEN_WIDTH'(1);
        if (pop) begin
          emit_left <= emit_left - LEN_WIDTH'(1);
          rd_count  <= rd_count + LEN_WIDTH'(1);
        end
      end
      if (push) begin
        skid[wr_ptr] <= fifo_rd_data;
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + 3'd1;
        2'b01:   occupancy <= occupancy - 3'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
